gemm_tile_sequencer: RTL and testbench

Controller that sequences one GEMM tile through the weight-stationary systolic array. Per command it:
- optionally loads a new weight tile into the inactive weight bank, then flips the active bank;
- streams M activation rows into the array;
- waits for the pipeline to drain and flags each result row at the array output.

It sits between the tile command queue / operand buffers and the systolic array top, and drives its sys2d_en, wt_load_en, wt_sel_bit and act_data_sel inputs.

---
 rtl/gemm_tile_sequencer.sv | 106 ++++++++++
 tb/tb_gemm_tile_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: sequences one GEMM tile (weight load, activation stream, drain) through the systolic array.
// Define GEMM_SEQ_PERF_EN to add the busy/stall performance counters.
module gemm_tile_sequencer #(
  parameter int SYS_ARRAY_HEIGHT = 16,
  parameter int SYS_ARRAY_WIDTH  = 16,
  parameter int ROW_W            = 16,
  parameter int DRAIN_LAT        = 96
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [ROW_W-1:0]                    cmd_rows,
  input  logic                                cmd_load_wt,
  input  logic                                stall,
  output logic                                wt_req,
  output logic [$clog2(SYS_ARRAY_HEIGHT)-1:0] wt_row_idx,
  output logic [SYS_ARRAY_WIDTH-1:0]          wt_load_en,
  output logic                                wt_sel_bit,
  output logic                                act_req,
  output logic [ROW_W-1:0]                    act_row_idx,
  output logic [SYS_ARRAY_HEIGHT-1:0]         act_data_sel,
  output logic                                sys2d_en,
  output logic                                out_valid,
  output logic [ROW_W-1:0]                    out_row_idx,
  output logic                                busy,
`ifdef GEMM_SEQ_PERF_EN
  input  logic                                perf_clr,
  output logic [31:0]                         perf_busy_cyc,
  output logic [31:0]                         perf_stall_cyc,
  output logic                                done
`else
  output logic                                done
`endif
);
  localparam int WI = $clog2(SYS_ARRAY_HEIGHT);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ROW_W-1:0] rows_q, act_cnt, out_cnt;
  logic [WI-1:0] wt_cnt;
  logic [DRAIN_LAT-1:0] dly;
  logic en;
  assign busy         = state != IDLE;
  assign en           = busy & ~stall;
  assign sys2d_en     = en;
  assign cmd_ready    = (state == IDLE) & reset;
  assign wt_req       = en & (state == LOAD);
  assign wt_load_en   = {SYS_ARRAY_WIDTH{wt_req}};
  assign wt_row_idx   = state == LOAD ? wt_cnt : '0;
  assign act_req      = en & (state == STREAM);
  assign act_data_sel = {SYS_ARRAY_HEIGHT{act_req}};
  assign act_row_idx  = state == STREAM ? act_cnt : '0;
  assign out_valid    = en & dly[DRAIN_LAT-1];
  assign out_row_idx  = busy ? out_cnt : '0;
  assign done         = state == DONE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nx = cmd_load_wt ? LOAD : (cmd_rows != '0 ? STREAM : DONE);
      LOAD:    if (en && wt_cnt == '0) state_nx = rows_q != '0 ? STREAM : DONE;
      STREAM:  if (en && act_cnt == rows_q - ROW_W'(1)) state_nx = DRAIN;
      DRAIN:   if (out_valid && out_cnt + ROW_W'(1) == rows_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      rows_q     <= '0;
      wt_cnt     <= '0;
      act_cnt    <= '0;
      out_cnt    <= '0;
      wt_sel_bit <= 1'b0;
      dly        <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        rows_q  <= cmd_rows;
        wt_cnt  <= WI'(SYS_ARRAY_HEIGHT - 1);
        act_cnt <= '0;
        out_cnt <= '0;
      end
      // row 0 goes in last; the bank flips once the final row has been shifted in
      if (wt_req) begin
        wt_cnt <= wt_cnt - WI'(1);
        if (wt_cnt == '0) wt_sel_bit <= ~wt_sel_bit;
      end
      if (act_req) act_cnt <= act_cnt + ROW_W'(1);
      if (out_valid) out_cnt <= out_cnt + ROW_W'(1);
      if (en) dly <= (dly << 1) | DRAIN_LAT'(act_req);
    end
`ifdef GEMM_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (perf_clr) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && !(&perf_busy_cyc)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (busy && stall && !(&perf_stall_cyc)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
`endif
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: directed scoreboard bench; expected events are queued with their cycle offset from command accept.
module tb_gemm_tile_sequencer;
  localparam int H = 4, W = 4, RW = 16, L = 10;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_load_wt = 0, stall = 0;
  logic [RW-1:0] cmd_rows = '0;
  logic cmd_ready, wt_req, wt_sel_bit, act_req, sys2d_en, out_valid, busy, done;
  logic [$clog2(H)-1:0] wt_row_idx;
  logic [W-1:0] wt_load_en;
  logic [RW-1:0] act_row_idx, out_row_idx;
  logic [H-1:0] act_data_sel;
`ifdef GEMM_SEQ_PERF_EN
  logic perf_clr = 0;
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif
  typedef struct {int k; int i; int t;} ev_t;
  ev_t exp_q[$];
  int ntests = 0, nfail = 0, cyc = 0, acc = 0;

  gemm_tile_sequencer #(.SYS_ARRAY_HEIGHT(H), .SYS_ARRAY_WIDTH(W), .ROW_W(RW), .DRAIN_LAT(L)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .cmd_load_wt(cmd_load_wt), .stall(stall), .wt_req(wt_req), .wt_row_idx(wt_row_idx),
    .wt_load_en(wt_load_en), .wt_sel_bit(wt_sel_bit), .act_req(act_req), .act_row_idx(act_row_idx),
    .act_data_sel(act_data_sel), .sys2d_en(sys2d_en), .out_valid(out_valid), .out_row_idx(out_row_idx),
    .busy(busy),
`ifdef GEMM_SEQ_PERF_EN
    .perf_clr(perf_clr), .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc),
`endif
    .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(int k, int i, int t);
    exp_q.push_back('{k, i, t});
  endtask

  // kinds: 0 weight row, 1 activation row, 2 result row, 3 done
  always @(negedge clk) if (reset) begin : mon
    logic [3:0] act;
    int idx[4];
    ev_t e;
    act = {done, out_valid, act_req, wt_req};
    idx[0] = int'(wt_row_idx); idx[1] = int'(act_row_idx); idx[2] = int'(out_row_idx); idx[3] = 0;
    for (int k = 0; k < 4; k++) if (act[k]) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL event: unexpected kind=%0d idx=%0d t=%0d", k, idx[k], cyc - acc);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || e.i != idx[k] || e.t != cyc - acc) begin
          nfail++;
          $display("FAIL event: got kind=%0d idx=%0d t=%0d expected kind=%0d idx=%0d t=%0d",
                   k, idx[k], cyc - acc, e.k, e.i, e.t);
        end
      end
    end
    if (wt_req) chk("wt_load_en", int'(wt_load_en), 4'hf);
    if (act_req) chk("act_data_sel", int'(act_data_sel), 4'hf);
    if (done) chk("cmd_ready_in_done", int'(cmd_ready), 0);
  end

  task automatic cmd(int rows, bit ld);
    @(posedge clk); #1;
    chk("cmd_ready", int'(cmd_ready), 1);
    cmd_valid = 1; cmd_rows = RW'(rows); cmd_load_wt = ld; acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wt_sel", int'(wt_sel_bit), 0);
    chk("rst_sys2d_en", int'(sys2d_en), 0);
    reset = 1;
    #1 chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    // 1: load + 3 rows
    for (int i = 0; i < 4; i++) push(0, 3 - i, 1 + i);
    for (int i = 0; i < 3; i++) push(1, i, 5 + i);
    for (int i = 0; i < 3; i++) push(2, i, 15 + i);
    push(3, 0, 18);
    cmd(3, 1);
    wait_idle();
    chk("s1_wt_sel", int'(wt_sel_bit), 1);
    // 2: reuse bank, 2 rows
    for (int i = 0; i < 2; i++) push(1, i, 1 + i);
    for (int i = 0; i < 2; i++) push(2, i, 11 + i);
    push(3, 0, 13);
    cmd(2, 0);
    wait_idle();
    chk("s2_wt_sel", int'(wt_sel_bit), 1);
    // 3: scenario 1 with stalls at offsets 6-8 (stream) and 13-14 (drain)
`ifdef GEMM_SEQ_PERF_EN
    @(posedge clk); #1 perf_clr = 1;
    @(posedge clk); #1 perf_clr = 0;
    chk("perf_clr_busy", int'(perf_busy_cyc), 0);
`endif
    for (int i = 0; i < 4; i++) push(0, 3 - i, 1 + i);
    push(1, 0, 5); push(1, 1, 9); push(1, 2, 10);
    for (int i = 0; i < 3; i++) push(2, i, 20 + i);
    push(3, 0, 23);
    cmd(3, 1);
    for (int n = 1; n < 16; n++) begin
      stall = (n >= 6 && n <= 8) || n == 13 || n == 14;
      #1;
      if (n == 7) begin
        chk("s3_stall_sys2d_en", int'(sys2d_en), 0);
        chk("s3_stall_act_req", int'(act_req), 0);
        chk("s3_stall_act_idx", int'(act_row_idx), 1);
      end
      if (n == 13) chk("s3_stall_drain_en", int'(sys2d_en), 0);
      @(posedge clk); #1;
    end
    stall = 0;
    wait_idle();
    chk("s3_wt_sel", int'(wt_sel_bit), 0);
`ifdef GEMM_SEQ_PERF_EN
    chk("perf_busy", int'(perf_busy_cyc), 23);
    chk("perf_stall", int'(perf_stall_cyc), 5);
`endif
    // 4: zero rows, without and with load
    push(3, 0, 1);
    cmd(0, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) push(0, 3 - i, 1 + i);
    push(3, 0, 5);
    cmd(0, 1);
    wait_idle();
    chk("s4_wt_sel", int'(wt_sel_bit), 1);
`ifdef GEMM_SEQ_PERF_EN
    push(1, 0, 2); push(2, 0, 12); push(3, 0, 13);
    cmd(1, 0);
    stall = 1; perf_clr = 1;
    @(posedge clk); #1;
    stall = 0; perf_clr = 0;
    chk("perf_clr_prio_busy", int'(perf_busy_cyc), 0);
    chk("perf_clr_prio_stall", int'(perf_stall_cyc), 0);
    wait_idle();
`endif
    // 5: reset in the middle of an 8-row stream
    push(1, 0, 1); push(1, 1, 2);
    cmd(8, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("s5_act_req", int'(act_req), 0);
    chk("s5_act_data_sel", int'(act_data_sel), 0);
    chk("s5_sys2d_en", int'(sys2d_en), 0);
    chk("s5_busy", int'(busy), 0);
    chk("s5_cmd_ready", int'(cmd_ready), 0);
    chk("s5_wt_sel", int'(wt_sel_bit), 0);
    chk("s5_act_idx", int'(act_row_idx), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1 chk("s5_release_ready", int'(cmd_ready), 1);
    push(1, 0, 1); push(2, 0, 11); push(3, 0, 12);
    cmd(1, 0);
    wait_idle();
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
